// File: rtl/dcache_refill.sv
// D-cache miss refill engine: issues one 4-beat AXI-style read burst per miss,
// merges pending store bytes into the target word and writes the line to the data RAM.
module dcache_refill #(
   parameter int ADDR_W  = 32,
   parameter int INDEX_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [ADDR_W-1:0]  req_addr,
   input  logic [INDEX_W-1:0] req_index,
   input  logic [3:0]         req_wstrb,
   input  logic [31:0]        req_wdata,
   output logic               ar_valid,
   input  logic               ar_ready,
   output logic [ADDR_W-1:0]  ar_addr,
   output logic [7:0]         ar_len,
   output logic [2:0]         ar_size,
   input  logic               r_valid,
   output logic               r_ready,
   input  logic [31:0]        r_data,
   input  logic               r_last,
   input  logic [1:0]         r_resp,
   output logic [15:0]        ram_we,
   output logic [INDEX_W-1:0] ram_w_index,
   output logic [127:0]       ram_data,
   output logic               done,
   output logic               err,
   output logic [31:0]        done_word
);

   typedef enum logic [2:0] {IDLE, AR, RD, FILL, DONE} state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    addr_q;
   logic [INDEX_W-1:0]   index_q;
   logic [3:0]           wstrb_q;
   logic [31:0]          wdata_q;
   logic                 err_q;
   logic [1:0]           cnt_q;
   logic [31:0]          line_q [4];
   logic                 beat;
   logic [31:0]          beat_word;

   assign ar_len  = 8'd3;
   assign ar_size = 3'd2;
   assign beat    = (state_q == RD) && r_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      req_ready   = 1'b0;
      ar_valid    = 1'b0;
      ar_addr     = '0;
      r_ready     = 1'b0;
      ram_we      = '0;
      ram_w_index = '0;
      ram_data    = '0;
      done        = 1'b0;
      err         = 1'b0;
      done_word   = '0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = AR;
         end
         AR: begin
            ar_valid = 1'b1;
            ar_addr  = {addr_q[ADDR_W-1:4], 4'b0000};
            if (ar_ready) state_d = RD;
         end
         RD: begin
            r_ready = 1'b1;
            if (r_valid && (cnt_q == 2'd3 || r_last)) state_d = FILL;
         end
         FILL: begin
            ram_we      = err_q ? 16'h0000 : 16'hFFFF;
            ram_w_index = index_q;
            ram_data    = {line_q[3], line_q[2], line_q[1], line_q[0]};
            state_d     = DONE;
         end
         DONE: begin
            done      = 1'b1;
            err       = err_q;
            done_word = line_q[addr_q[3:2]];
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Store bytes override the fetched bytes only in the word the store targets.
   always_comb begin
      beat_word = r_data;
      for (int unsigned b = 0; b < 4; b++) begin
         if (cnt_q == addr_q[3:2] && wstrb_q[b]) beat_word[8*b +: 8] = wdata_q[8*b +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         index_q <= '0;
         wstrb_q <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         for (int unsigned i = 0; i < 4; i++) line_q[i] <= '0;
      end else begin
         if (state_q == IDLE && req_valid) begin
            addr_q  <= req_addr;
            index_q <= req_index;
            wstrb_q <= req_wstrb;
            wdata_q <= req_wdata;
            err_q   <= 1'b0;
            cnt_q   <= '0;
         end
         if (beat) begin
            line_q[cnt_q] <= beat_word;
            cnt_q         <= cnt_q + 2'd1;
            // r_last must coincide exactly with the fourth beat; either mismatch is an error.
            if (r_resp != 2'b00 || ((cnt_q == 2'd3) != r_last)) err_q <= 1'b1;
            if (cnt_q != 2'd3 && r_last) begin
               for (int unsigned i = 0; i < 4; i++) begin
                  if (i > 32'(cnt_q)) line_q[i[1:0]] <= '0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_dcache_refill.sv
// Self-checking bench for dcache_refill: random and directed refills, scoreboard
// of expected line/err/done_word checked by an independent monitor.
module tb_dcache_refill;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid, req_ready;
   logic [31:0]  req_addr;
   logic [2:0]   req_index;
   logic [3:0]   req_wstrb;
   logic [31:0]  req_wdata;
   logic         ar_valid, ar_ready;
   logic [31:0]  ar_addr;
   logic [7:0]   ar_len;
   logic [2:0]   ar_size;
   logic         r_valid, r_ready, r_last;
   logic [31:0]  r_data;
   logic [1:0]   r_resp;
   logic [15:0]  ram_we;
   logic [2:0]   ram_w_index;
   logic [127:0] ram_data;
   logic         done, err;
   logic [31:0]  done_word;

   dcache_refill #(.ADDR_W(32), .INDEX_W(3)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_index(req_index), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
      .ar_len(ar_len), .ar_size(ar_size),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
      .r_last(r_last), .r_resp(r_resp),
      .ram_we(ram_we), .ram_w_index(ram_w_index), .ram_data(ram_data),
      .done(done), .err(err), .done_word(done_word)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] line;
      logic         err;
      logic [31:0]  dword;
      logic [2:0]   idx;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   // Per-transaction slave behaviour
   logic [31:0] tx_data [4];
   logic [1:0]  tx_resp [4];
   int          tx_last;    // beat index carrying r_last, 4 = never asserted
   int          tx_ardly;   // cycles ar_ready is held low
   int          tx_vmode;   // 0 = r_valid always 1, 1 = random
   bit          vq[$];      // explicit r_valid pattern, consumed first

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [2:0] idx,
                                  input logic [3:0] ws, input logic [31:0] wd);
      exp_t e;
      int n;
      logic [31:0] w;
      n = (tx_last < 3) ? tx_last + 1 : 4;
      e.err = (tx_last != 3);
      e.idx = idx;
      e.line = '0;
      for (int i = 0; i < 4; i++) begin
         w = '0;
         if (i < n) begin
            w = tx_data[i];
            if (tx_resp[i] != 2'b00) e.err = 1'b1;
            if (i == int'(a[3:2])) begin
               for (int b = 0; b < 4; b++) if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
            end
         end
         e.line[32*i +: 32] = w;
      end
      e.dword = e.line[32*int'(a[3:2]) +: 32];
      return e;
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, req_ready, 1);
      chk({tag, "_ar_valid"}, ar_valid, 0);
      chk({tag, "_ar_addr"}, ar_addr, 0);
      chk({tag, "_ar_len"}, ar_len, 3);
      chk({tag, "_ar_size"}, ar_size, 2);
      chk({tag, "_r_ready"}, r_ready, 0);
      chk({tag, "_ram_we"}, ram_we, 0);
      chk({tag, "_ram_idx"}, ram_w_index, 0);
      chk({tag, "_ram_data"}, ram_data, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_done_word"}, done_word, 0);
   endtask

   // abort >= 0: pull reset after that many beats instead of completing
   task automatic run_txn(input logic [31:0] a, input logic [2:0] idx, input logic [3:0] ws,
                          input logic [31:0] wd, input bit check_lat, input int abort);
      int n, k, budget, w;
      time t0;
      bit v;
      logic [31:0] exp_ar;
      exp_ar = {a[31:4], 4'b0000};
      n = (tx_last < 3) ? tx_last + 1 : 4;
      w = 0;
      while (!req_ready && w < 20) begin @(negedge clk); w++; end
      chk("idle_before_req", req_ready, 1);
      req_addr = a; req_index = idx; req_wstrb = ws; req_wdata = wd; req_valid = 1'b1;
      if (abort < 0) sb.push_back(model(a, idx, ws, wd));
      t0 = $time;
      @(negedge clk);
      req_valid = 1'b0;
      chk("ar_valid_c1", ar_valid, 1);
      chk("ar_addr", ar_addr, exp_ar);
      chk("req_ready_busy", req_ready, 0);
      for (int d = 0; d < tx_ardly; d++) begin
         ar_ready = 1'b0;
         @(negedge clk);
         chk("ar_hold_valid", ar_valid, 1);
         chk("ar_hold_addr", ar_addr, exp_ar);
      end
      ar_ready = 1'b1;
      @(negedge clk);
      ar_ready = 1'b0;
      chk("rd_entry_r_ready", r_ready, 1);
      chk("rd_entry_ar_valid", ar_valid, 0);
      k = 0;
      budget = 0;
      while (k < n && budget < 60) begin
         if (vq.size() > 0) v = vq.pop_front();
         else if (tx_vmode == 1) v = 1'($urandom % 2);
         else v = 1'b1;
         r_valid = v;
         r_data  = tx_data[k];
         r_resp  = tx_resp[k];
         r_last  = (k == tx_last);
         // stray requests while busy must not be latched
         if ($urandom % 3 == 0) begin req_valid = 1'b1; req_addr = $urandom; req_wstrb = 4'hF; end
         else req_valid = 1'b0;
         @(negedge clk);
         if (v) k++;
         budget++;
         if (abort >= 0 && k == abort) break;
      end
      r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00; req_valid = 1'b0;
      if (budget >= 60) chk("beat_budget", 0, 1);
      if (abort >= 0) begin
         rst = 1'b0;
         #1;
         chk_reset_outputs("midrst");
         r_valid = 1'b1; r_last = 1'b1; r_data = 32'hDEADBEEF;
         @(negedge clk);
         rst = 1'b1;
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_r_ready", r_ready, 0);
            chk("post_rst_done", done, 0);
            chk("post_rst_req_ready", req_ready, 1);
         end
         r_valid = 1'b0; r_last = 1'b0;
         return;
      end
      w = 0;
      while (!done && w < 10) begin @(negedge clk); w++; end
      chk("done_seen", done, 1);
      if (check_lat) chk("latency", (($time - t0) / 10), 7);
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("back_idle", req_ready, 1);
   endtask

   task automatic set_beats(input logic [31:0] d0, d1, d2, d3);
      tx_data[0] = d0; tx_data[1] = d1; tx_data[2] = d2; tx_data[3] = d3;
      for (int i = 0; i < 4; i++) tx_resp[i] = 2'b00;
      tx_last = 3; tx_ardly = 0; tx_vmode = 0; vq.delete();
   endtask

   // Monitor: FILL is the cycle before the done pulse, so RAM outputs are held one cycle.
   logic [15:0]  p_we;
   logic [2:0]   p_idx;
   logic [127:0] p_data;
   exp_t         me;
   always @(negedge clk) begin
      if (rst && done) begin
         if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_done actual=1 required=0");
         end else begin
            me = sb.pop_front();
            chk("done_err", err, me.err);
            chk("done_word", done_word, me.dword);
            chk("fill_we", p_we, me.err ? 16'h0000 : 16'hFFFF);
            chk("fill_idx", p_idx, me.idx);
            if (!me.err) chk("fill_data", p_data, me.line);
            chk("done_ram_we", ram_we, 0);
         end
      end
      p_we = ram_we; p_idx = ram_w_index; p_data = ram_data;
   end

   initial begin
      rst = 1'b0;
      req_valid = 0; req_addr = '0; req_index = '0; req_wstrb = '0; req_wdata = '0;
      ar_ready = 0; r_valid = 0; r_data = '0; r_last = 0; r_resp = '0;
      #1;
      chk_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outputs("after_release");

      // Load miss, minimum latency
      set_beats(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
      run_txn(32'h00001234, 3'd3, 4'b0000, 32'h0, 1'b1, -1);

      // Store miss merging two low bytes into word 2
      set_beats(32'h33333333, 32'h33333333, 32'h33333333, 32'h33333333);
      run_txn(32'h00002008, 3'd5, 4'b0011, 32'hAABBCCDD, 1'b1, -1);

      // ar_ready held low for 5 cycles
      set_beats(32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3);
      tx_ardly = 5;
      run_txn(32'h8000_0F3C, 3'd1, 4'b0000, 32'h0, 1'b0, -1);

      // Gappy r_valid
      set_beats(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
      vq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      run_txn(32'h0000_0044, 3'd7, 4'b1000, 32'h99000000, 1'b0, -1);

      // Error response on beat 1
      set_beats(32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0);
      tx_resp[1] = 2'd2;
      run_txn(32'h0000_1000, 3'd2, 4'b0000, 32'h0, 1'b0, -1);

      // Early r_last on beat 1 (remaining words zeroed, err)
      set_beats(32'hCAFEF00D, 32'hBEEFBEEF, 32'h77777777, 32'h88888888);
      tx_last = 1;
      run_txn(32'h0000_300C, 3'd4, 4'b0000, 32'h0, 1'b0, -1);

      // Missing r_last on the fourth beat
      set_beats(32'h10101010, 32'h20202020, 32'h30303030, 32'h40404040);
      tx_last = 4;
      run_txn(32'h0000_4004, 3'd6, 4'b0000, 32'h0, 1'b0, -1);

      // Reset after 2 beats, then a clean load miss
      set_beats(32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888);
      run_txn(32'h0000_5000, 3'd2, 4'b0000, 32'h0, 1'b0, 2);
      set_beats(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
      run_txn(32'h00001234, 3'd3, 4'b0000, 32'h0, 1'b1, -1);

      // Randomized refills
      for (int t = 0; t < 25; t++) begin
         set_beats($urandom, $urandom, $urandom, $urandom);
         for (int i = 0; i < 4; i++) tx_resp[i] = ($urandom % 8 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         tx_last  = ($urandom % 4 == 0) ? int'($urandom_range(0, 4)) : 3;
         tx_ardly = $urandom_range(0, 3);
         tx_vmode = 1;
         run_txn($urandom, 3'($urandom), ($urandom % 2 == 0) ? 4'b0000 : 4'($urandom),
                 $urandom, 1'b0, -1);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
